rv32_mem_arbiter: RTL and testbench

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

---
 rtl/rv32_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port, one transaction in flight.
// Define RV32_MEM_ARB_FAIR_EN for round-robin arbitration; otherwise data has fixed priority.
module rv32_mem_arbiter #(
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_in,
  input  logic [31:0] instr_addr_in,
  output logic        instr_ready_out,
  output logic [31:0] instr_rdata_out,
  output logic        instr_rvalid_out,
  input  logic        data_req_in,
  input  logic        data_write_in,
  input  logic [31:0] data_addr_in,
  input  logic [31:0] data_wdata_in,
  input  logic [3:0]  data_wmask_in,
  output logic        data_ready_out,
  output logic [31:0] data_rdata_out,
  output logic        data_rvalid_out,
  output logic        mem_req_out,
  output logic        mem_write_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wmask_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_rvalid_in,
  output logic        err_out
);

  localparam int CW = $clog2(RESP_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_instr_q;
  logic [CW-1:0]   cnt_q;
  logic            any_req;
  logic            grant_instr;
  logic            grant_write;
  logic            timeout_hit;
  logic            wait_done;
  logic            instr_ready_d, data_ready_d;
  logic            instr_rvalid_d, data_rvalid_d;
  logic            err_d;
  logic [31:0]     resp_data_d;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^instr_addr_in[1:0];
  assign any_req          = instr_req_in | data_req_in;
  assign grant_write      = ~grant_instr & data_write_in;
  assign timeout_hit      = (cnt_q == CW'(RESP_TIMEOUT - 1));
  assign wait_done        = mem_rvalid_in | timeout_hit;

`ifdef RV32_MEM_ARB_FAIR_EN
  logic last_instr_q;

  // On contention the port that did not win last time gets the grant.
  assign grant_instr = instr_req_in & (~data_req_in | ~last_instr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_instr_q <= 1'b1;
    end else if (state_q == S_IDLE && any_req) begin
      last_instr_q <= grant_instr;
    end
  end
`else
  assign grant_instr = instr_req_in & ~data_req_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (mem_ready_in) state_d = mem_write_out ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered handshake/response outputs.
  always_comb begin
    instr_ready_d  = 1'b0;
    data_ready_d   = 1'b0;
    instr_rvalid_d = 1'b0;
    data_rvalid_d  = 1'b0;
    err_d          = 1'b0;
    resp_data_d    = '0;
    case (state_q)
      S_IDLE: begin
        instr_ready_d = any_req & grant_instr;
        data_ready_d  = any_req & ~grant_instr;
      end
      S_ISSUE: begin
        data_rvalid_d = mem_ready_in & mem_write_out;
      end
      S_WAIT: begin
        if (wait_done) begin
          instr_rvalid_d = owner_instr_q;
          data_rvalid_d  = ~owner_instr_q;
          err_d          = ~mem_rvalid_in;
          resp_data_d    = mem_rvalid_in ? mem_rdata_in : 32'h0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_ready_out  <= 1'b0;
      instr_rvalid_out <= 1'b0;
      instr_rdata_out  <= '0;
      data_ready_out   <= 1'b0;
      data_rvalid_out  <= 1'b0;
      data_rdata_out   <= '0;
      err_out          <= 1'b0;
      mem_req_out      <= 1'b0;
      mem_write_out    <= 1'b0;
      mem_addr_out     <= '0;
      mem_wdata_out    <= '0;
      mem_wmask_out    <= '0;
      owner_instr_q    <= 1'b0;
      cnt_q            <= '0;
    end else begin
      instr_ready_out  <= instr_ready_d;
      data_ready_out   <= data_ready_d;
      instr_rvalid_out <= instr_rvalid_d;
      data_rvalid_out  <= data_rvalid_d;
      err_out          <= err_d;
      instr_rdata_out  <= instr_rvalid_d ? resp_data_d : 32'h0;
      data_rdata_out   <= data_rvalid_d ? resp_data_d : 32'h0;
      mem_req_out      <= (state_d == S_ISSUE);

      // Latched fields stay on mem_* until the next grant.
      if (state_q == S_IDLE && any_req) begin
        owner_instr_q <= grant_instr;
        mem_write_out <= grant_write;
        mem_addr_out  <= grant_instr ? {instr_addr_in[31:2], 2'b00} : data_addr_in;
        mem_wdata_out <= grant_write ? data_wdata_in : 32'h0;
        mem_wmask_out <= grant_write ? data_wmask_in : 4'b0000;
      end

      if (state_q == S_WAIT) begin
        if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter; a transaction-level model predicts grants and response timing.
module tb_rv32_mem_arbiter;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_in;
  logic [31:0] instr_addr_in;
  logic        instr_ready_out;
  logic [31:0] instr_rdata_out;
  logic        instr_rvalid_out;
  logic        data_req_in;
  logic        data_write_in;
  logic [31:0] data_addr_in;
  logic [31:0] data_wdata_in;
  logic [3:0]  data_wmask_in;
  logic        data_ready_out;
  logic [31:0] data_rdata_out;
  logic        data_rvalid_out;
  logic        mem_req_out;
  logic        mem_write_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wmask_out;
  logic        mem_ready_in;
  logic [31:0] mem_rdata_in;
  logic        mem_rvalid_in;
  logic        err_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  // memory behaviour for the next transaction: ready after mem_k stall cycles,
  // response in WAIT cycle mem_r (mem_r >= T means never)
  int          mem_k;
  int          mem_r;
  logic [31:0] mem_resp;
  bit          m_last_instr;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.RESP_TIMEOUT(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_req_in     (instr_req_in),
    .instr_addr_in    (instr_addr_in),
    .instr_ready_out  (instr_ready_out),
    .instr_rdata_out  (instr_rdata_out),
    .instr_rvalid_out (instr_rvalid_out),
    .data_req_in      (data_req_in),
    .data_write_in    (data_write_in),
    .data_addr_in     (data_addr_in),
    .data_wdata_in    (data_wdata_in),
    .data_wmask_in    (data_wmask_in),
    .data_ready_out   (data_ready_out),
    .data_rdata_out   (data_rdata_out),
    .data_rvalid_out  (data_rvalid_out),
    .mem_req_out      (mem_req_out),
    .mem_write_out    (mem_write_out),
    .mem_addr_out     (mem_addr_out),
    .mem_wdata_out    (mem_wdata_out),
    .mem_wmask_out    (mem_wmask_out),
    .mem_ready_in     (mem_ready_in),
    .mem_rdata_in     (mem_rdata_in),
    .mem_rvalid_in    (mem_rvalid_in),
    .err_out          (err_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    instr_req_in  = 1'b0;
    instr_addr_in = '0;
    data_req_in   = 1'b0;
    data_write_in = 1'b0;
    data_addr_in  = '0;
    data_wdata_in = '0;
    data_wmask_in = '0;
    mem_ready_in  = 1'b0;
    mem_rdata_in  = '0;
    mem_rvalid_in = 1'b0;
    tick();
    tick();
    reset        = 1'b0;
    m_last_instr = 1'b1;
  endtask

  // Runs one transaction from the IDLE cycle where requests are presented
  // (cycle 0) to its completion cycle; returns with time at completion.
  task automatic do_txn(input bit win_i);
    logic        e_write;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic [1:0]  e_ready;
    logic [1:0]  e_rvalid;
    logic [31:0] e_data;
    logic        e_err;
    logic [31:0] got_data;
    e_write = !win_i && data_write_in;
    e_addr  = win_i ? {instr_addr_in[31:2], 2'b00} : data_addr_in;
    e_wdata = data_wdata_in;
    e_mask  = e_write ? data_wmask_in : 4'b0000;
    mem_ready_in  = 1'b0;
    mem_rvalid_in = 1'b0;
    tick();
    for (int j = 0; j <= mem_k; j++) begin
      e_ready = (j == 0) ? (win_i ? 2'b10 : 2'b01) : 2'b00;
      vec_cnt++;
      if ({instr_ready_out, data_ready_out} !== e_ready) begin
        err_cnt++;
        $display("FAIL ready: got %b expected %b (issue cycle %0d)", {instr_ready_out, data_ready_out}, e_ready, j);
      end
      vec_cnt++;
      if (mem_req_out !== 1'b1) begin
        err_cnt++;
        $display("FAIL mem_req: got %b expected 1 (issue cycle %0d)", mem_req_out, j);
      end
      vec_cnt++;
      if ({mem_write_out, mem_addr_out, mem_wmask_out} !== {e_write, e_addr, e_mask}) begin
        err_cnt++;
        $display("FAIL mem_fields: got w=%b a=%h m=%b expected w=%b a=%h m=%b",
                 mem_write_out, mem_addr_out, mem_wmask_out, e_write, e_addr, e_mask);
      end
      if (e_write) begin
        vec_cnt++;
        if (mem_wdata_out !== e_wdata) begin
          err_cnt++;
          $display("FAIL mem_wdata: got %h expected %h", mem_wdata_out, e_wdata);
        end
      end
      vec_cnt++;
      if ({instr_rvalid_out, data_rvalid_out, err_out} !== 3'b000) begin
        err_cnt++;
        $display("FAIL issue_quiet: got rv=%b%b err=%b expected 000", instr_rvalid_out, data_rvalid_out, err_out);
      end
      if (j == 0) begin
        if (win_i) instr_req_in = 1'b0;
        else       data_req_in  = 1'b0;
      end
      mem_ready_in  = (j == mem_k);
      mem_rvalid_in = 1'($urandom_range(0, 1));
      mem_rdata_in  = $urandom;
      tick();
    end
    mem_ready_in  = 1'b0;
    mem_rvalid_in = 1'b0;
    vec_cnt++;
    if (mem_req_out !== 1'b0) begin
      err_cnt++;
      $display("FAIL mem_req_drop: got %b expected 0", mem_req_out);
    end
    if (!e_write) begin
      for (int w = 0; w < T; w++) begin
        vec_cnt++;
        if ({instr_ready_out, data_ready_out, instr_rvalid_out, data_rvalid_out, err_out} !== 5'b0) begin
          err_cnt++;
          $display("FAIL wait_quiet: got rdy=%b%b rv=%b%b err=%b expected all 0 (wait cycle %0d)",
                   instr_ready_out, data_ready_out, instr_rvalid_out, data_rvalid_out, err_out, w);
        end
        mem_rvalid_in = (w == mem_r);
        mem_rdata_in  = (w == mem_r) ? mem_resp : $urandom;
        tick();
        if (w == mem_r) break;
      end
      mem_rvalid_in = 1'b0;
    end
    e_rvalid = (win_i && !e_write) ? 2'b10 : 2'b01;
    e_data   = (e_write || mem_r >= T) ? 32'h0 : mem_resp;
    e_err    = !e_write && mem_r >= T;
    got_data = win_i ? instr_rdata_out : data_rdata_out;
    vec_cnt++;
    if ({instr_rvalid_out, data_rvalid_out} !== e_rvalid) begin
      err_cnt++;
      $display("FAIL rvalid: got %b expected %b", {instr_rvalid_out, data_rvalid_out}, e_rvalid);
    end
    vec_cnt++;
    if (got_data !== e_data) begin
      err_cnt++;
      $display("FAIL rdata: got %h expected %h", got_data, e_data);
    end
    vec_cnt++;
    if (err_out !== e_err) begin
      err_cnt++;
      $display("FAIL err_out: got %b expected %b", err_out, e_err);
    end
    vec_cnt++;
    if ({instr_ready_out, data_ready_out} !== 2'b00) begin
      err_cnt++;
      $display("FAIL done_ready: got %b expected 00", {instr_ready_out, data_ready_out});
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vec_cnt++;
    if ({instr_ready_out, instr_rvalid_out, instr_rdata_out, data_ready_out, data_rvalid_out, data_rdata_out,
         mem_req_out, mem_write_out, mem_addr_out, mem_wdata_out, mem_wmask_out, err_out} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got mem_req=%b addr=%h rv=%b%b expected all 0",
               mem_req_out, mem_addr_out, instr_rvalid_out, data_rvalid_out);
    end
  endtask

  task automatic test_fetch_basic();
    apply_reset();
    instr_req_in  = 1'b1;
    instr_addr_in = 32'h0000_0100;
    mem_k = 0; mem_r = 0; mem_resp = 32'hDEAD_BEEF;
    do_txn(1'b1);
  endtask

  task automatic test_store_stall();
    apply_reset();
    data_req_in   = 1'b1;
    data_write_in = 1'b1;
    data_addr_in  = 32'h0000_0204;
    data_wdata_in = 32'h1122_3344;
    data_wmask_in = 4'b0011;
    mem_k = 2; mem_r = 0; mem_resp = '0;
    do_txn(1'b0);
  endtask

  task automatic test_timeout();
    apply_reset();
    data_req_in   = 1'b1;
    data_write_in = 1'b0;
    data_addr_in  = 32'h0000_0400;
    mem_k = 0; mem_r = 99; mem_resp = 32'hFFFF_FFFF;
    do_txn(1'b0);
    instr_req_in  = 1'b1;
    instr_addr_in = 32'h0000_0808;
    mem_k = 1; mem_r = 1; mem_resp = 32'hCAFE_F00D;
    do_txn(1'b1);
  endtask

  task automatic test_timeout_precedence();
    apply_reset();
    data_req_in   = 1'b1;
    data_write_in = 1'b0;
    data_addr_in  = 32'h0000_0500;
    mem_k = 0; mem_r = T - 1; mem_resp = 32'h0BAD_CAFE;
    do_txn(1'b0);
  endtask

  task automatic test_back_to_back();
    bit exp_i [6];
    apply_reset();
    for (int n = 0; n < 6; n++) begin
`ifdef RV32_MEM_ARB_FAIR_EN
      exp_i[n] = (n % 2) == 1;
`else
      exp_i[n] = 1'b0;
`endif
    end
    instr_req_in  = 1'b1;
    instr_addr_in = $urandom;
    data_req_in   = 1'b1;
    data_write_in = 1'b0;
    data_addr_in  = $urandom;
    for (int n = 0; n < 6; n++) begin
      mem_k = 0; mem_r = 0; mem_resp = $urandom;
      do_txn(exp_i[n]);
      if (exp_i[n]) begin
        instr_req_in  = 1'b1;
        instr_addr_in = $urandom;
      end else begin
        data_req_in  = 1'b1;
        data_addr_in = $urandom;
      end
    end
    instr_req_in = 1'b0;
    data_req_in  = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    bit win_i;
    apply_reset();
    for (int it = 0; it < 40; it++) begin
      if (!instr_req_in && $urandom_range(0, 1) == 1) begin
        instr_req_in  = 1'b1;
        instr_addr_in = $urandom;
      end
      if (!data_req_in && ($urandom_range(0, 1) == 1 || !instr_req_in)) begin
        data_req_in   = 1'b1;
        data_write_in = 1'($urandom_range(0, 1));
        data_addr_in  = $urandom;
        data_wdata_in = $urandom;
        data_wmask_in = 4'($urandom_range(0, 15));
      end
`ifdef RV32_MEM_ARB_FAIR_EN
      if (instr_req_in && data_req_in) win_i = !m_last_instr;
      else                             win_i = instr_req_in;
      m_last_instr = win_i;
`else
      win_i = !data_req_in;
`endif
      mem_k    = $urandom_range(0, 2);
      mem_r    = $urandom_range(0, 5);
      mem_resp = $urandom;
      do_txn(win_i);
    end
    instr_req_in = 1'b0;
    data_req_in  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    data_req_in   = 1'b1;
    data_write_in = 1'b0;
    data_addr_in  = 32'h0000_0300;
    tick();
    data_req_in  = 1'b0;
    mem_ready_in = 1'b1;
    tick();
    mem_ready_in = 1'b0;
    reset        = 1'b1;
    tick();
    reset         = 1'b0;
    mem_rvalid_in = 1'b1;
    mem_rdata_in  = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      vec_cnt++;
      if ({instr_ready_out, instr_rvalid_out, instr_rdata_out, data_ready_out, data_rvalid_out, data_rdata_out,
           mem_req_out, mem_write_out, mem_addr_out, mem_wdata_out, mem_wmask_out, err_out} !== '0) begin
        err_cnt++;
        $display("FAIL reset_mid: got rv=%b%b err=%b mem_req=%b addr=%h expected all 0 (cycle %0d)",
                 instr_rvalid_out, data_rvalid_out, err_out, mem_req_out, mem_addr_out, c);
      end
      tick();
    end
    mem_rvalid_in = 1'b0;
    m_last_instr  = 1'b1;
    instr_req_in  = 1'b1;
    instr_addr_in = 32'h0000_0600;
    mem_k = 0; mem_r = 0; mem_resp = 32'h1234_5678;
    do_txn(1'b1);
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_store_stall();
    test_timeout();
    test_timeout_precedence();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
